fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the memory.
- Absorbs the memory's fixed 1-cycle registered read latency and presents {inst, pc} to the decoder over a valid/ready handshake.
- Handles branch redirects and fetch pause, with a 2-entry buffer so a stalled decoder never loses a returning instruction.

Parameters:
- RESET_PC, 0: PC loaded on reset.
- MEM_DEPTH, 256: instruction words in memory; PC arithmetic is modulo MEM_DEPTH (power of 2).
- CNT_W, 32: width of the fetched-instruction counter.

Ports:
- clock  in  1  rising-edge clock shared with instruction memory
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  1 = issue new fetches; 0 = pause issue (in-flight fetch still completes)
- mem_addr  out  64  word address to memory = PC register, zero-extended
- mem_inst  in  64  memory read data, valid the cycle after the address was sampled
- redirect_valid  in  1  branch/jump redirect strobe
- redirect_pc  in  64  redirect target; only low log2(MEM_DEPTH) bits used
- dec_valid  out  1  buffer head holds an instruction
- dec_ready  in  1  decoder accepts the head this cycle
- dec_inst  out  64  head instruction
- dec_pc  out  64  address the head instruction was fetched from
- fetch_count  out  CNT_W  instructions delivered to the decoder (dec_fire count)

Behaviour:
- State machine: BOOT -> RUN when fetch_en=1, else PAUSE. RUN <-> PAUSE follows fetch_en. PAUSE only stops issue; buffer and handshake operate normally.
- BOOT is a single cycle after reset deassertion with no issue; it covers memory preload.
- Reset (async, any cycle, including mid-operation):
  - pc=RESET_PC, inflight=0, count=0, state=BOOT, fetch_count=0.
  - dec_valid=0; dec_inst=0; dec_pc=0.
- Occupancy: occ = count + inflight, range 0..2.
- Definitions:
  - dec_fire = dec_valid & dec_ready.
  - issue = state==RUN & !redirect_valid & (occ<2 | (occ==2 & dec_fire)).
- On issue (posedge):
  - inflight<=1; inflight_pc<=pc; pc<=(pc+1) mod MEM_DEPTH.
  - No issue -> inflight<=0, pc holds.
- Return: cycle after issue, if inflight=1 and no redirect this cycle, {mem_inst, inflight_pc} is written to the buffer tail.
  - Throughput 1 instr/cycle when the decoder is always ready.
  - Issue-to-dec_valid latency is 2 cycles (memory register + buffer).
- Buffer: 2-entry FIFO of {inst, pc}; dec_inst/dec_pc driven from the head.
  - Simultaneous write and dec_fire: count unchanged, order preserved.
  - Credit rule guarantees no write when full; a write-when-full is an assertion failure.
- dec_valid = count!=0 & !redirect_valid. An instruction shown in a redirect cycle is not consumed, and fetch_count does not increment.
- Redirect (priority over everything except reset):
  - Same edge: count<=0, inflight<=0 (next-cycle mem_inst discarded), pc<=redirect_pc mod MEM_DEPTH.
  - Target issues the following cycle if RUN; first target instruction reaches dec_valid 3 cycles after the redirect edge.
- Back-to-back redirects: last one wins; no stale instruction is ever delivered.
- Redirect while PAUSE or BOOT: pc updates, buffer flushes, state unchanged.
- Wrap-around: pc=MEM_DEPTH-1 issues, then pc=0.
- fetch_count increments on dec_fire and wraps at 2^CNT_W.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, RUN, PAUSE}.
  - INST_W=64, ADDR_W=64.
  - Packed struct fetch_entry_t {inst, pc}.
- Sub-module fetch_buffer: 2-entry FIFO with push, pop, flush, count, head; instantiated once.
- PC, FSM, credit logic and counter stay in fetch_unit.

Test Plan:
- Reset, fetch_en=1, dec_ready=1, memory preloaded word k = k+100 -> mem_addr sequence 0,1,2,…; dec_valid first at cycle 3 after reset release; dec_inst/dec_pc = (100,0),(101,1),(102,2); fetch_count=3 after three fires.
- dec_ready=0 for 5 cycles mid-stream -> count reaches 2; issue stops with pc held; on release, instructions resume in order with none lost or duplicated.
- redirect_valid with redirect_pc=40 while buffer is full and inflight=1:
  - dec_valid drops that cycle; old entries are never delivered.
  - mem_addr=40 next cycle; dec_pc=40 with dec_inst=140 three cycles after the redirect edge.
- fetch_en=0 for 4 cycles -> at most the in-flight instruction is delivered, pc frozen; fetch_en=1 resumes at the next sequential pc.
- PC at 254 with MEM_DEPTH=256 -> dec_pc sequence 254,255,0,1; also redirect_pc=300 -> fetches 44.
- reset asserted mid-stream (buffer full) -> outputs zero asynchronously before the next edge; after release the stream restarts at RESET_PC following the BOOT cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, bus widths and
// the {inst, pc} entry carried from memory return to the decoder.
package fetch_pkg;

  localparam int INST_W = 64;
  localparam int ADDR_W = 64;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {inst, pc}; head is always visible, flush empties
// it in one edge, and a simultaneous push/pop keeps the occupancy unchanged.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slots [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slots[0] <= '0;
      slots[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = slots[rd_ptr];

  // The upstream credit check must make a push into a full buffer impossible.
  a_no_push_when_full : assert property (
    @(posedge clock) disable iff (reset) !(push && count == 2'd2)
  );

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues word addresses to a 1-cycle-latency memory,
// buffers returning instructions and hands {inst, pc} to the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_DEPTH = 256,
  parameter int                CNT_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int PC_W = $clog2(MEM_DEPTH);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [1:0]      buf_count;
  logic [1:0]      occ;
  logic            dec_fire;
  logic            issue;
  logic            push;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_redirect_hi;

  // Handshake: the head transfers on any edge where dec_valid && dec_ready;
  // dec_valid never depends on dec_ready, and a redirect cycle hides the head.
  assign dec_valid = (buf_count != 2'd0) && !redirect_valid;
  assign dec_fire  = dec_valid && dec_ready;

  // Credit counts the in-flight fetch, so a return always finds a free slot.
  assign occ   = buf_count + {1'b0, inflight};
  assign issue = (state == RUN) && !redirect_valid &&
                 ((occ < 2'd2) || ((occ == 2'd2) && dec_fire));
  assign push  = inflight && !redirect_valid;

  assign push_data.inst = mem_inst;
  assign push_data.pc   = {{(ADDR_W-PC_W){1'b0}}, inflight_pc};

  assign mem_addr = {{(ADDR_W-PC_W){1'b0}}, pc};
  assign dec_inst = head.inst;
  assign dec_pc   = head.pc;

  assign unused_redirect_hi = ^redirect_pc[ADDR_W-1:PC_W];

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = fetch_en ? RUN : PAUSE;
      RUN:     state_next = fetch_en ? RUN : PAUSE;
      PAUSE:   state_next = fetch_en ? RUN : PAUSE;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC[PC_W-1:0];
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc       <= redirect_pc[PC_W-1:0];
        inflight <= 1'b0;
      end else if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + PC_W'(1);
      end else begin
        inflight <= 1'b0;
      end
      if (dec_fire) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

  fetch_buffer u_buffer (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (dec_fire),
    .flush     (redirect_valid),
    .count     (buf_count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based model of buffer, in-flight
// fetch and PC predicts every cycle; scenario tasks add targeted checks.
module tb_fetch_unit;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_ready;
  logic [63:0] mem_addr;
  logic [63:0] mem_inst;
  logic        dec_valid;
  logic [63:0] dec_inst;
  logic [63:0] dec_pc;
  logic [31:0] fetch_count;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(64'd0), .MEM_DEPTH(256), .CNT_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .mem_addr       (mem_addr),
    .mem_inst       (mem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .fetch_count    (fetch_count)
  );

  // Instruction memory: word k holds k+100, registered read.
  logic [63:0] imem [256];
  always @(posedge clock) mem_inst <= imem[mem_addr[7:0]];

  // ---------------- reference model ----------------
  logic [127:0] exp_q[$];   // buffered {inst, pc}, head first
  int           m_fly[$];   // pc of the fetch whose data returns next cycle
  int           m_pc;
  bit           m_run;      // issue permitted this cycle
  logic [31:0]  m_cnt;

  logic        e_valid;
  logic [63:0] e_addr, e_inst, e_pc;
  logic [31:0] e_cnt;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [63:0] exp_word(int pc);
    return 64'(pc + 100);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_fly.delete();
    m_pc  = 0;
    m_run = 0;
    m_cnt = '0;
  endtask

  task automatic predict();
    e_valid = (exp_q.size() != 0) && !redirect_valid;
    e_addr  = 64'(m_pc);
    e_cnt   = m_cnt;
    e_inst  = '0;
    e_pc    = '0;
    if (exp_q.size() != 0) {e_inst, e_pc} = exp_q[0];
  endtask

  task automatic model_step();
    int occ;
    bit fire;
    bit issue;
    fire  = e_valid && dec_ready;
    occ   = exp_q.size() + m_fly.size();
    issue = m_run && !redirect_valid && (occ < 2 || (occ == 2 && fire));
    if (redirect_valid) begin
      exp_q.delete();
      m_fly.delete();
      m_pc = int'(redirect_pc % 64'd256);
    end else begin
      if (fire) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (m_fly.size() != 0) begin
        exp_q.push_back({exp_word(m_fly[0]), 64'(m_fly[0])});
        m_fly.delete();
      end
      if (issue) begin
        m_fly.push_back(m_pc);
        m_pc = (m_pc + 1) % 256;
      end
    end
    m_run = fetch_en;
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge clock);
    predict();
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; fetch_en = 1'b0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if ({dec_valid, dec_inst, dec_pc, fetch_count, mem_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%0b inst=%0d pc=%0d cnt=%0d addr=%0d want all 0",
               dec_valid, dec_inst, dec_pc, fetch_count, mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    int first = -1;
    logic [127:0] got[$];
    logic [31:0]  cnt6 = '1;
    fetch_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      n_vec++;
      if ({dec_valid, mem_addr, fetch_count} !== {e_valid, e_addr, e_cnt}) begin
        n_err++;
        $display("FAIL stream_ctl cyc=%0d got v/addr/cnt=%0b/%0d/%0d want %0b/%0d/%0d",
                 i, dec_valid, mem_addr, fetch_count, e_valid, e_addr, e_cnt);
      end
      if (e_valid) begin
        n_vec++;
        if ({dec_inst, dec_pc} !== {e_inst, e_pc}) begin
          n_err++;
          $display("FAIL stream_head cyc=%0d got %0d@%0d want %0d@%0d", i, dec_inst, dec_pc, e_inst, e_pc);
        end
      end
      if (dec_valid && first < 0) first = i;
      if (dec_valid && dec_ready) got.push_back({dec_inst, dec_pc});
      if (i == 6) cnt6 = fetch_count;
      advance();
    end
    n_vec++;
    if (first !== 3) begin
      n_err++;
      $display("FAIL stream_first_valid got cycle %0d want 3", first);
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got.size() <= k || got[k] !== {64'(100 + k), 64'(k)}) begin
        n_err++;
        $display("FAIL stream_seq%0d got %0h want inst=%0d pc=%0d", k,
                 (got.size() > k) ? got[k] : 128'd0, 100 + k, k);
      end
    end
    n_vec++;
    if (cnt6 !== 32'd3) begin
      n_err++;
      $display("FAIL stream_count got %0d want 3", cnt6);
    end
  endtask

  task automatic test_stall();
    bit have = 0;
    logic [63:0] seq = '0;
    for (int i = 0; i < 14; i++) begin
      dec_ready = (i >= 5);
      settle();
      n_vec++;
      if ({dec_valid, mem_addr, fetch_count} !== {e_valid, e_addr, e_cnt}) begin
        n_err++;
        $display("FAIL stall_ctl cyc=%0d got v/addr/cnt=%0b/%0d/%0d want %0b/%0d/%0d",
                 i, dec_valid, mem_addr, fetch_count, e_valid, e_addr, e_cnt);
      end
      if (e_valid) begin
        n_vec++;
        if ({dec_inst, dec_pc} !== {e_inst, e_pc}) begin
          n_err++;
          $display("FAIL stall_head cyc=%0d got %0d@%0d want %0d@%0d", i, dec_inst, dec_pc, e_inst, e_pc);
        end
      end
      if (dec_valid && dec_ready) begin
        if (!have) begin seq = e_pc; have = 1; end
        n_vec++;
        if (dec_pc !== seq || dec_inst !== seq + 64'd100) begin
          n_err++;
          $display("FAIL stall_order got %0d@%0d want %0d@%0d", dec_inst, dec_pc, seq + 64'd100, seq);
        end
        seq = (seq + 64'd1) % 64'd256;
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    int first = -1;
    fetch_en = 1'b1;
    for (int i = -2; i <= 8; i++) begin
      dec_ready      = (i >= 0);
      redirect_valid = (i == 0);
      redirect_pc    = 64'd40;
      settle();
      n_vec++;
      if ({dec_valid, mem_addr, fetch_count} !== {e_valid, e_addr, e_cnt}) begin
        n_err++;
        $display("FAIL redirect_ctl cyc=%0d got v/addr/cnt=%0b/%0d/%0d want %0b/%0d/%0d",
                 i, dec_valid, mem_addr, fetch_count, e_valid, e_addr, e_cnt);
      end
      if (e_valid) begin
        n_vec++;
        if ({dec_inst, dec_pc} !== {e_inst, e_pc}) begin
          n_err++;
          $display("FAIL redirect_head cyc=%0d got %0d@%0d want %0d@%0d", i, dec_inst, dec_pc, e_inst, e_pc);
        end
      end
      if (i == 0) begin
        n_vec++;
        if (dec_valid !== 1'b0) begin
          n_err++;
          $display("FAIL redirect_drop got dec_valid=%0b want 0", dec_valid);
        end
      end
      if (i == 1) begin
        n_vec++;
        if (mem_addr !== 64'd40) begin
          n_err++;
          $display("FAIL redirect_addr got %0d want 40", mem_addr);
        end
      end
      if (i > 0 && dec_valid && first < 0) begin
        first = i;
        n_vec++;
        if (i != 3 || {dec_inst, dec_pc} !== {64'd140, 64'd40}) begin
          n_err++;
          $display("FAIL redirect_target got %0d@%0d at +%0d want 140@40 at +3", dec_inst, dec_pc, i);
        end
      end
      advance();
    end
    n_vec++;
    if (first < 0) begin
      n_err++;
      $display("FAIL redirect_timeout got no dec_valid want one within 8 cycles");
    end
    // back-to-back redirects: the later target must be the only one delivered
    first = -1;
    for (int i = 0; i < 9; i++) begin
      redirect_valid = (i < 2);
      redirect_pc    = (i == 0) ? 64'd70 : 64'd90;
      settle();
      n_vec++;
      if ({dec_valid, mem_addr, fetch_count} !== {e_valid, e_addr, e_cnt}) begin
        n_err++;
        $display("FAIL b2b_ctl cyc=%0d got v/addr/cnt=%0b/%0d/%0d want %0b/%0d/%0d",
                 i, dec_valid, mem_addr, fetch_count, e_valid, e_addr, e_cnt);
      end
      if (i >= 2 && dec_valid && first < 0) begin
        first = i;
        n_vec++;
        if ({dec_inst, dec_pc} !== {64'd190, 64'd90}) begin
          n_err++;
          $display("FAIL b2b_target got %0d@%0d want 190@90", dec_inst, dec_pc);
        end
      end
      advance();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_pause();
    logic [63:0] seq = 64'd20;
    fetch_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      redirect_valid = (i == 0);
      redirect_pc    = 64'd20;
      fetch_en       = !(i >= 9 && i < 13);
      settle();
      n_vec++;
      if ({dec_valid, mem_addr, fetch_count} !== {e_valid, e_addr, e_cnt}) begin
        n_err++;
        $display("FAIL pause_ctl cyc=%0d got v/addr/cnt=%0b/%0d/%0d want %0b/%0d/%0d",
                 i, dec_valid, mem_addr, fetch_count, e_valid, e_addr, e_cnt);
      end
      if (i == 12) begin
        n_vec++;
        if (dec_valid !== 1'b0) begin
          n_err++;
          $display("FAIL pause_drain got dec_valid=%0b want 0", dec_valid);
        end
      end
      if (dec_valid && dec_ready) begin
        n_vec++;
        if (dec_pc !== seq || dec_inst !== seq + 64'd100) begin
          n_err++;
          $display("FAIL pause_order got %0d@%0d want %0d@%0d", dec_inst, dec_pc, seq + 64'd100, seq);
        end
        seq = seq + 64'd1;
      end
      advance();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_w[4] = '{254, 255, 0, 1};
    int got[$];
    int first = -1;
    fetch_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      redirect_valid = (i == 0);
      redirect_pc    = 64'd254;
      settle();
      n_vec++;
      if ({dec_valid, mem_addr, fetch_count} !== {e_valid, e_addr, e_cnt}) begin
        n_err++;
        $display("FAIL wrap_ctl cyc=%0d got v/addr/cnt=%0b/%0d/%0d want %0b/%0d/%0d",
                 i, dec_valid, mem_addr, fetch_count, e_valid, e_addr, e_cnt);
      end
      if (e_valid) begin
        n_vec++;
        if ({dec_inst, dec_pc} !== {e_inst, e_pc}) begin
          n_err++;
          $display("FAIL wrap_head cyc=%0d got %0d@%0d want %0d@%0d", i, dec_inst, dec_pc, e_inst, e_pc);
        end
      end
      if (dec_valid && dec_ready) got.push_back(int'(dec_pc));
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (got.size() <= k || got[k] != exp_w[k]) begin
        n_err++;
        $display("FAIL wrap_seq%0d got %0d want %0d", k, (got.size() > k) ? got[k] : -1, exp_w[k]);
      end
    end
    // out-of-range target folds modulo the memory depth
    for (int i = 0; i < 8; i++) begin
      redirect_valid = (i == 0);
      redirect_pc    = 64'd300;
      settle();
      if (i == 1) begin
        n_vec++;
        if (mem_addr !== 64'd44) begin
          n_err++;
          $display("FAIL wrap_fold_addr got %0d want 44", mem_addr);
        end
      end
      if (i > 0 && dec_valid && first < 0) begin
        first = i;
        n_vec++;
        if ({dec_inst, dec_pc} !== {64'd144, 64'd44}) begin
          n_err++;
          $display("FAIL wrap_fold_head got %0d@%0d want 144@44", dec_inst, dec_pc);
        end
      end
      advance();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = {$urandom, $urandom};
      settle();
      n_vec++;
      if ({dec_valid, mem_addr, fetch_count} !== {e_valid, e_addr, e_cnt}) begin
        n_err++;
        $display("FAIL random_ctl cyc=%0d got v/addr/cnt=%0b/%0d/%0d want %0b/%0d/%0d",
                 i, dec_valid, mem_addr, fetch_count, e_valid, e_addr, e_cnt);
      end
      if (e_valid) begin
        n_vec++;
        if ({dec_inst, dec_pc} !== {e_inst, e_pc}) begin
          n_err++;
          $display("FAIL random_head cyc=%0d got %0d@%0d want %0d@%0d", i, dec_inst, dec_pc, e_inst, e_pc);
        end
      end
      advance();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    fetch_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      redirect_valid = (i == 0);
      redirect_pc    = 64'd10;
      dec_ready      = (i < 7);
      settle();
      advance();
    end
    redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({dec_valid, dec_inst, dec_pc, fetch_count, mem_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_async got v=%0b inst=%0d pc=%0d cnt=%0d addr=%0d want all 0",
               dec_valid, dec_inst, dec_pc, fetch_count, mem_addr);
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      n_vec++;
      if ({dec_valid, mem_addr, fetch_count} !== {e_valid, e_addr, e_cnt}) begin
        n_err++;
        $display("FAIL restart_ctl cyc=%0d got v/addr/cnt=%0b/%0d/%0d want %0b/%0d/%0d",
                 i, dec_valid, mem_addr, fetch_count, e_valid, e_addr, e_cnt);
      end
      if (dec_valid && first < 0) begin
        first = i;
        n_vec++;
        if (i != 3 || {dec_inst, dec_pc} !== {64'd100, 64'd0}) begin
          n_err++;
          $display("FAIL restart_first got %0d@%0d at cyc %0d want 100@0 at cyc 3", dec_inst, dec_pc, i);
        end
      end
      advance();
    end
    n_vec++;
    if (first < 0) begin
      n_err++;
      $display("FAIL restart_timeout got no dec_valid want one within 10 cycles");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 256; k++) imem[k] = 64'(k + 100);
    mem_inst = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_pause();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got time limit reached want scenario completion");
    $fatal(1, "watchdog");
  end

endmodule
